// File: rtl/sequenciador_arrolhamento.sv
// -----------------------------------------------------------------------------
// sequenciador_arrolhamento
//
// Sequencer for a bottle corking station. It moves the conveyor until a bottle
// arrives, lets it settle, waits for a cork if the feeder is empty, drives the
// cork press for a fixed time, then releases the bottle. Each bottle consumes
// exactly one cork, so one 'dec' pulse goes to the cork counter per bottle.
// A bottle that does not leave the station in time puts the block in ERRO.
//
// Parameters
//   T_ASSENTAR  cycles the bottle settles before corking
//   T_ATUADOR   cycles the cork actuator is held
//   T_LIBERAR   maximum cycles for the bottle to leave the station
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous, active-high reset
//   start                level; starts the line from PARADO or clears ERRO
//   stop                 level; stop request (honoured in PARADO, MOVER, ESPERA_ROLHA)
//   sensor_garrafa       bottle present at the corking station
//   rolha_disponivel     cork counter holds at least one cork
//   alarme_rolhas        cork counter and stock empty
//   motor_esteira        conveyor motor enable
//   dec                  one-cycle cork-consume pulse
//   atuador_rolha        cork press actuator
//   falta_rolha          high while waiting for a cork
//   erro                 high in ERRO
//   estado               current state encoding
//   garrafas_arrolhadas  completed bottle count, saturating at 255
// -----------------------------------------------------------------------------
module sequenciador_arrolhamento #(
    parameter int T_ASSENTAR = 4,
    parameter int T_ATUADOR  = 8,
    parameter int T_LIBERAR  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       sensor_garrafa,
    input  logic       rolha_disponivel,
    input  logic       alarme_rolhas,
    output logic       motor_esteira,
    output logic       dec,
    output logic       atuador_rolha,
    output logic       falta_rolha,
    output logic       erro,
    output logic [2:0] estado,
    output logic [7:0] garrafas_arrolhadas
);

    localparam logic [2:0] PARADO       = 3'd0;
    localparam logic [2:0] MOVER        = 3'd1;
    localparam logic [2:0] POSICIONAR   = 3'd2;
    localparam logic [2:0] ESPERA_ROLHA = 3'd3;
    localparam logic [2:0] ARROLHAR     = 3'd4;
    localparam logic [2:0] LIBERAR      = 3'd5;
    localparam logic [2:0] ERRO         = 3'd6;

    localparam int T_MAX_AL = (T_ASSENTAR > T_ATUADOR) ? T_ASSENTAR : T_ATUADOR;
    localparam int T_MAX    = (T_MAX_AL > T_LIBERAR) ? T_MAX_AL : T_LIBERAR;
    localparam int TW       = $clog2(T_MAX + 1);

    // Timer holds (cycles already spent in the state); a state lasting N
    // cycles therefore exits when the timer shows N-1.
    localparam logic [TW-1:0] LIM_ASSENTAR = TW'(T_ASSENTAR - 1);
    localparam logic [TW-1:0] LIM_ATUADOR  = TW'(T_ATUADOR - 1);
    localparam logic [TW-1:0] LIM_LIBERAR  = TW'(T_LIBERAR - 1);

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [TW-1:0] timer;
    logic          sensor_prev;
    logic          sensor_rise;

    assign sensor_rise = sensor_garrafa & ~sensor_prev;

    always_comb begin
        next_state = state;
        case (state)
            PARADO: begin
                if (start && !stop)
                    next_state = MOVER;
            end
            MOVER: begin
                if (stop)
                    next_state = PARADO;
                else if (sensor_rise)
                    next_state = POSICIONAR;
            end
            POSICIONAR: begin
                if (timer == LIM_ASSENTAR)
                    next_state = rolha_disponivel ? ARROLHAR : ESPERA_ROLHA;
            end
            ESPERA_ROLHA: begin
                if (stop)
                    next_state = PARADO;
                else if (rolha_disponivel)
                    next_state = ARROLHAR;
            end
            ARROLHAR: begin
                if (timer == LIM_ATUADOR)
                    next_state = LIBERAR;
            end
            LIBERAR: begin
                if (!sensor_garrafa)
                    next_state = MOVER;
                else if (timer == LIM_LIBERAR)
                    next_state = ERRO;
            end
            ERRO: begin
                if (start && !sensor_garrafa)
                    next_state = MOVER;
            end
            default: next_state = PARADO;
        endcase
    end

    // State, timer and the sensor edge detector. The timer saturates so that
    // long stays in PARADO/MOVER/ESPERA_ROLHA/ERRO never wrap into a limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PARADO;
            timer       <= '0;
            sensor_prev <= 1'b0;
        end else begin
            state       <= next_state;
            sensor_prev <= sensor_garrafa;
            if (next_state != state)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with estado
    // in the same cycle. dec fires only on the edge that enters ARROLHAR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            motor_esteira       <= 1'b0;
            dec                 <= 1'b0;
            atuador_rolha       <= 1'b0;
            falta_rolha         <= 1'b0;
            erro                <= 1'b0;
            estado              <= PARADO;
            garrafas_arrolhadas <= 8'd0;
        end else begin
            motor_esteira <= (next_state == MOVER) || (next_state == LIBERAR);
            dec           <= (next_state == ARROLHAR) && (state != ARROLHAR);
            atuador_rolha <= (next_state == ARROLHAR);
            falta_rolha   <= (next_state == ESPERA_ROLHA) ||
                             (alarme_rolhas && (next_state == POSICIONAR));
            erro          <= (next_state == ERRO);
            estado        <= next_state;
            if ((state == ARROLHAR) && (next_state == LIBERAR) &&
                (garrafas_arrolhadas != 8'hFF))
                garrafas_arrolhadas <= garrafas_arrolhadas + 8'd1;
        end
    end

endmodule

// File: tb/tb_sequenciador_arrolhamento.sv
// -----------------------------------------------------------------------------
// tb_sequenciador_arrolhamento
//
// Directed scenarios (nominal bottle, cork shortage, stop mid-bottle, release
// timeout, asynchronous reset, counter saturation) followed by a random phase.
// Every cycle all outputs are compared with a behavioural model that tracks the
// station by named phase and cycles-spent-in-phase.
// -----------------------------------------------------------------------------
module tb_sequenciador_arrolhamento;

    localparam int T_ASSENTAR = 4;
    localparam int T_ATUADOR  = 8;
    localparam int T_LIBERAR  = 64;

    localparam int S_PARADO = 0, S_MOVER = 1, S_POSIC = 2, S_ESPERA = 3,
                   S_ARROL = 4, S_LIBERAR = 5, S_ERRO = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, sensor_garrafa, rolha_disponivel, alarme_rolhas;
    logic       motor_esteira, dec, atuador_rolha, falta_rolha, erro;
    logic [2:0] estado;
    logic [7:0] garrafas_arrolhadas;

    sequenciador_arrolhamento #(
        .T_ASSENTAR(T_ASSENTAR),
        .T_ATUADOR (T_ATUADOR),
        .T_LIBERAR (T_LIBERAR)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .stop               (stop),
        .sensor_garrafa     (sensor_garrafa),
        .rolha_disponivel   (rolha_disponivel),
        .alarme_rolhas      (alarme_rolhas),
        .motor_esteira      (motor_esteira),
        .dec                (dec),
        .atuador_rolha      (atuador_rolha),
        .falta_rolha        (falta_rolha),
        .erro               (erro),
        .estado             (estado),
        .garrafas_arrolhadas(garrafas_arrolhadas)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model
    int m_phase;
    int m_spent;
    int m_bottles;
    bit m_prev_sensor;
    bit m_dec;
    bit m_falta;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase       = S_PARADO;
        m_spent       = 0;
        m_bottles     = 0;
        m_prev_sensor = 1'b0;
        m_dec         = 1'b0;
        m_falta       = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        int nxt;
        int done;
        if (reset) begin
            model_reset();
            return;
        end
        nxt  = m_phase;
        done = m_spent + 1;   // cycles in this phase once this edge completes
        case (m_phase)
            S_PARADO:  if (start && !stop) nxt = S_MOVER;
            S_MOVER:   if (stop) nxt = S_PARADO;
                       else if (sensor_garrafa && !m_prev_sensor) nxt = S_POSIC;
            S_POSIC:   if (done == T_ASSENTAR) nxt = rolha_disponivel ? S_ARROL : S_ESPERA;
            S_ESPERA:  if (stop) nxt = S_PARADO;
                       else if (rolha_disponivel) nxt = S_ARROL;
            S_ARROL:   if (done == T_ATUADOR) begin
                           nxt = S_LIBERAR;
                           if (m_bottles < 255) m_bottles++;
                       end
            S_LIBERAR: if (!sensor_garrafa) nxt = S_MOVER;
                       else if (done == T_LIBERAR) nxt = S_ERRO;
            S_ERRO:    if (start && !sensor_garrafa) nxt = S_MOVER;
            default:   nxt = S_PARADO;
        endcase
        m_dec         = (nxt == S_ARROL) && (m_phase != S_ARROL);
        m_falta       = (nxt == S_ESPERA) || (nxt == S_POSIC && alarme_rolhas);
        m_spent       = (nxt != m_phase) ? 0 : done;
        m_prev_sensor = sensor_garrafa;
        m_phase       = nxt;
    endtask

    task automatic compare_all();
        chk("estado",  32'(estado), 32'(m_phase));
        chk("motor",   32'(motor_esteira), 32'(m_phase == S_MOVER || m_phase == S_LIBERAR));
        chk("atuador", 32'(atuador_rolha), 32'(m_phase == S_ARROL));
        chk("erro",    32'(erro), 32'(m_phase == S_ERRO));
        chk("dec",     32'(dec), 32'(m_dec));
        chk("falta",   32'(falta_rolha), 32'(m_falta));
        chk("contagem", 32'(garrafas_arrolhadas), 32'(m_bottles));
    endtask

    // Inputs change at the falling edge; outputs are checked at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_phase(input string tag, input int target, input int budget);
        int n = 0;
        while (m_phase != target && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(estado), 32'(target));
    endtask

    // One full bottle from MOVER with the sensor low.
    task automatic bottle();
        sensor_garrafa = 1'b1;
        wait_phase("bot_lib", S_LIBERAR, 40);
        sensor_garrafa = 1'b0;
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; sensor_garrafa = 1'b0;
        rolha_disponivel = 1'b1; alarme_rolhas = 1'b0;
        model_reset();
        cycle();
        cycle();
        chk("reset_estado", 32'(estado), 32'd0);
        reset = 1'b0;

        // Stays in PARADO without start
        for (int i = 0; i < 3; i++) cycle();
        chk("idle_parado", 32'(estado), 32'd0);

        // Nominal bottle
        start = 1'b1;
        cycle();
        chk("n_mover", 32'(estado), 32'd1);
        start = 1'b0;
        sensor_garrafa = 1'b1;
        for (int i = 0; i < T_ASSENTAR; i++) begin
            cycle();
            chk("n_posic", 32'(estado), 32'd2);
        end
        for (int i = 0; i < T_ATUADOR; i++) begin
            cycle();
            chk("n_arrol", 32'(estado), 32'd4);
            chk("n_dec", 32'(dec), 32'(i == 0));
        end
        cycle();
        chk("n_liberar", 32'(estado), 32'd5);
        sensor_garrafa = 1'b0;
        cycle();
        chk("n_volta_mover", 32'(estado), 32'd1);
        chk("n_contagem", 32'(garrafas_arrolhadas), 32'd1);

        // Cork shortage
        rolha_disponivel = 1'b0;
        sensor_garrafa = 1'b1;
        wait_phase("f_espera", S_ESPERA, 10);
        chk("f_falta", 32'(falta_rolha), 32'd1);
        chk("f_nodec", 32'(dec), 32'd0);
        cycle();
        cycle();
        chk("f_ainda", 32'(estado), 32'd3);
        rolha_disponivel = 1'b1;
        cycle();
        chk("f_arrol", 32'(estado), 32'd4);
        chk("f_dec", 32'(dec), 32'd1);
        cycle();
        chk("f_dec_unico", 32'(dec), 32'd0);
        wait_phase("f_lib", S_LIBERAR, 20);
        sensor_garrafa = 1'b0;
        cycle();

        // Stop during ARROLHAR: bottle completes, then stop taken in MOVER
        sensor_garrafa = 1'b1;
        wait_phase("s_arrol", S_ARROL, 10);
        stop = 1'b1;
        wait_phase("s_lib", S_LIBERAR, 20);
        sensor_garrafa = 1'b0;
        cycle();
        chk("s_mover", 32'(estado), 32'd1);
        cycle();
        chk("s_parado", 32'(estado), 32'd0);
        chk("s_contagem", 32'(garrafas_arrolhadas), 32'd3);
        stop = 1'b0;

        // Release timeout into ERRO, then recovery
        start = 1'b1;
        cycle();
        start = 1'b0;
        sensor_garrafa = 1'b1;
        wait_phase("e_lib", S_LIBERAR, 20);
        for (int i = 0; i < T_LIBERAR - 1; i++) cycle();
        chk("e_lib_hold", 32'(estado), 32'd5);
        cycle();
        chk("e_estado", 32'(estado), 32'd6);
        chk("e_flag", 32'(erro), 32'd1);
        start = 1'b1;
        cycle();
        chk("e_sensor_alto", 32'(estado), 32'd6);
        sensor_garrafa = 1'b0;
        cycle();
        chk("e_recupera", 32'(estado), 32'd1);
        start = 1'b0;

        // Asynchronous reset in the middle of ARROLHAR
        sensor_garrafa = 1'b1;
        wait_phase("r_arrol", S_ARROL, 10);
        cycle();
        cycle();
        chk("r_atuador_antes", 32'(atuador_rolha), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("r_atuador_async", 32'(atuador_rolha), 32'd0);
        chk("r_contagem_async", 32'(garrafas_arrolhadas), 32'd0);
        chk("r_estado_async", 32'(estado), 32'd0);
        model_reset();
        sensor_garrafa = 1'b0;
        @(negedge clk);
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("r_pos_reset", 32'(estado), 32'd0);

        // Counter saturation
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int b = 0; b < 260; b++) bottle();
        chk("sat_255", 32'(garrafas_arrolhadas), 32'd255);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            start            = ($urandom_range(0, 15) == 0);
            stop             = ($urandom_range(0, 31) == 0);
            rolha_disponivel = ($urandom_range(0, 3) != 0);
            alarme_rolhas    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) sensor_garrafa = ~sensor_garrafa;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
